// File: rtl/approx_err_pkg.sv
// approx_err_pkg: shared FSM state type, drain depth and width helpers for the error monitor
package approx_err_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_state_t;
  localparam int DRAIN_CYC = 2;
  function automatic int ed_w(input int w);
    return w + 1;
  endfunction
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int acc_w(input int w, input int p);
    return 2 * w + p + 2;
  endfunction
endpackage

// File: rtl/approx_lower_or_add.sv
// approx_lower_or_add: lower-part-OR approximate adder, combinational
// Ports: a_i, b_i (W bits) operands; y_o (W+1 bits) approximate sum.
// The P low bits are a plain OR; the upper part is an exact adder whose
// carry-in is the AND of the top approximated bit pair (0 when P=0).
module approx_lower_or_add #(
  parameter int W = 6,
  parameter int P = 3
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   y_o
);
  logic [W:0] cy;
  assign cy[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_bit
    if (i < P) begin : g_or
      assign y_o[i]  = a_i[i] | b_i[i];
      assign cy[i+1] = (i == P - 1) ? (a_i[i] & b_i[i]) : 1'b0;
    end else begin : g_add
      assign y_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
      assign cy[i+1] = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & cy[i]);
    end
  end
  assign y_o[W] = cy[W];
endmodule

// File: rtl/approx_add_err_monitor.sv
// approx_add_err_monitor: exhaustive sweep of an approximate adder, accumulating error metrics
// Ports: clk, rst (sync, active-high); start, abort control; busy, done status;
// err_count, sum_abs_err, max_abs_err results (held until the next accepted start).
// Optional: define APPROX_ERR_BIAS_EN to add sum_signed_err, the signed sum of errors.
module approx_add_err_monitor
  import approx_err_pkg::*;
#(
  parameter int W     = 6,
  parameter int P     = 3,
  parameter int ACC_W = acc_w(W, P)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_w(W)-1:0]   err_count,
  output logic [ACC_W-1:0]      sum_abs_err,
  output logic [ed_w(W)-1:0]    max_abs_err
`ifdef APPROX_ERR_BIAS_EN
  ,output logic signed [ACC_W:0] sum_signed_err
`endif
);
  localparam int CW = 2 * W;
  localparam int NW = cnt_w(W);
  localparam int EW = ed_w(W);
  localparam logic [1:0] DLAST = 2'(DRAIN_CYC - 1);
  fsm_state_t     state_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     dcnt_q;
  logic           busy_q, done_q;
  logic [W:0]     y_app, y_ex, ya_q, ye_q;
  logic           v1_q, v2_q, nz_q;
  logic [W+1:0]   e_d, e_q;
  logic [EW-1:0]  ae, max_q;
  logic [NW-1:0]  err_q;
  logic [NW:0]    err_n;
  logic [ACC_W-1:0] sabs_q;
  logic [ACC_W:0]   sabs_n;
  logic           clr, kill, run_ok;
  // Control: sweep counter {A,B}, drain countdown and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        RUN: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CW'(1);
          if (&cnt_q) begin
            state_q <= DRAIN;
            dcnt_q  <= '0;
          end
        end
        DRAIN: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (dcnt_q == DLAST) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          dcnt_q <= dcnt_q + 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  approx_lower_or_add #(.W(W), .P(P)) u_app (
    .a_i(cnt_q[CW-1:W]),
    .b_i(cnt_q[W-1:0]),
    .y_o(y_app)
  );
  assign y_ex   = {1'b0, cnt_q[CW-1:W]} + {1'b0, cnt_q[W-1:0]};
  assign clr    = (state_q == IDLE) && start;
  assign kill   = abort && ((state_q == RUN) || (state_q == DRAIN));
  assign run_ok = (state_q == RUN) && !abort;
  assign e_d    = {1'b0, ya_q} - {1'b0, ye_q};
  assign ae     = e_q[W+1] ? (~e_q[W:0] + EW'(1)) : e_q[W:0];
  assign err_n  = {1'b0, err_q} + (NW+1)'(nz_q);
  assign sabs_n = {1'b0, sabs_q} + (ACC_W+1)'(ae);
`ifdef APPROX_ERR_BIAS_EN
  logic signed [ACC_W:0]   ssum_q;
  logic signed [ACC_W+1:0] ssum_n;
  assign ssum_n = {ssum_q[ACC_W], ssum_q} + {{(ACC_W-W){e_q[W+1]}}, e_q};
  // Signed saturation: clamp to the extreme matching the true sign on overflow
  always_ff @(posedge clk) begin
    if (rst || clr) ssum_q <= '0;
    else if (v2_q)
      ssum_q <= (ssum_n[ACC_W+1] != ssum_n[ACC_W])
        ? (ssum_n[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}})
        : ssum_n[ACC_W:0];
  end
  assign sum_signed_err = ssum_q;
`endif
  // Datapath: stage 1 sums, stage 2 error, then accumulate with saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ya_q   <= '0;
      ye_q   <= '0;
      e_q    <= '0;
      nz_q   <= 1'b0;
      err_q  <= '0;
      sabs_q <= '0;
      max_q  <= '0;
    end else begin
      v1_q <= run_ok;
      ya_q <= y_app;
      ye_q <= y_ex;
      v2_q <= v1_q && !kill;
      e_q  <= e_d;
      nz_q <= |e_d;
      if (clr) begin
        err_q  <= '0;
        sabs_q <= '0;
        max_q  <= '0;
      end else if (v2_q) begin
        err_q  <= err_n[NW] ? '1 : err_n[NW-1:0];
        sabs_q <= sabs_n[ACC_W] ? '1 : sabs_n[ACC_W-1:0];
        max_q  <= (ae > max_q) ? ae : max_q;
      end
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_q;
  assign sum_abs_err = sabs_q;
  assign max_abs_err = max_q;
endmodule
